// File: rtl/seg_glyph_pkg.sv
// Shared seven-segment glyph definitions, buffer entry type and hex decoder.
// Glyph bit order is {dot,a,b,c,d,e,f,g}, active-high.
package seg_glyph_pkg;

  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  localparam logic [7:0] GLYPH_0 = 8'h7E;
  localparam logic [7:0] GLYPH_1 = 8'h30;
  localparam logic [7:0] GLYPH_2 = 8'h6D;
  localparam logic [7:0] GLYPH_3 = 8'h79;
  localparam logic [7:0] GLYPH_4 = 8'h33;
  localparam logic [7:0] GLYPH_5 = 8'h5B;
  localparam logic [7:0] GLYPH_6 = 8'h5F;
  localparam logic [7:0] GLYPH_7 = 8'h70;
  localparam logic [7:0] GLYPH_8 = 8'h7F;
  localparam logic [7:0] GLYPH_9 = 8'h7B;
  localparam logic [7:0] GLYPH_HEX_A = 8'h77;
  localparam logic [7:0] GLYPH_HEX_B = 8'h1F;
  localparam logic [7:0] GLYPH_HEX_C = 8'h4E;
  localparam logic [7:0] GLYPH_HEX_D = 8'h3D;
  localparam logic [7:0] GLYPH_HEX_E = 8'h4F;
  localparam logic [7:0] GLYPH_HEX_F = 8'h47;

  // Letters used by the mode/score/song text ("start", "ready", ...)
  localparam logic [7:0] GLYPH_S = 8'h5B;
  localparam logic [7:0] GLYPH_T = 8'h0F;
  localparam logic [7:0] GLYPH_A = 8'h7D;
  localparam logic [7:0] GLYPH_R = 8'h05;
  localparam logic [7:0] GLYPH_B = 8'h1F;
  localparam logic [7:0] GLYPH_D = 8'h3D;
  localparam logic [7:0] GLYPH_Y = 8'h3B;
  localparam logic [7:0] GLYPH_E = 8'h6F;

  localparam logic [1:0] SPEED_SLOW   = 2'd0;
  localparam logic [1:0] SPEED_NORMAL = 2'd1;
  localparam logic [1:0] SPEED_FAST   = 2'd2;
  localparam logic [1:0] SPEED_TURBO  = 2'd3;

  typedef struct packed {
    logic [7:0] glyph;
    logic       blink;
  } seg_entry_t;

  function automatic logic [7:0] hex_to_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_HEX_A;
      4'hB:    g = GLYPH_HEX_B;
      4'hC:    g = GLYPH_HEX_C;
      4'hD:    g = GLYPH_HEX_D;
      4'hE:    g = GLYPH_HEX_E;
      default: g = GLYPH_HEX_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Glyph-buffer write port shared by the mode/score/song controllers.
// Handshake: wr_en acts as valid with an implicit always-high ready; every cycle
// with wr_en=1 is one accepted write, and clear=1 in the same cycle drops it.
interface seg_scan_driver_if #(parameter int N_DIGITS = 8);
  localparam int AW = $clog2(N_DIGITS);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_hex;
  logic [7:0]    wr_data;
  logic          wr_blink;
  logic          clear;

  modport master (output wr_en, wr_addr, wr_hex, wr_data, wr_blink, clear);
  modport slave  (input  wr_en, wr_addr, wr_hex, wr_data, wr_blink, clear);
endinterface

// File: rtl/seg_tick_gen.sv
// Free-running divider: tick is high for one cycle every REFRESH_DIV clocks.
module seg_tick_gen #(
  parameter int REFRESH_DIV = 200000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end
endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: glyph buffer with blink, circular
// scroll, registered segment/anode outputs and a frame-complete pulse.
module seg_scan_driver
  import seg_glyph_pkg::*;
#(
  parameter int N_DIGITS      = 8,
  parameter int REFRESH_DIV   = 200000,
  parameter int BLINK_FRAMES  = 32,
  parameter int SCROLL_FRAMES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                scroll_en,
  seg_scan_driver_if.slave    wr,
  output logic [7:0]          seg_out,
  output logic [N_DIGITS-1:0] an_out,
  output logic                frame_done
);
  localparam int AW = $clog2(N_DIGITS);
  localparam logic [AW-1:0] LAST = AW'(N_DIGITS - 1);

  seg_entry_t    buffer [N_DIGITS];
  logic          tick, wrap, wr_ok;
  logic [AW-1:0] scan_idx, scroll_off, sel_idx;
  logic [AW:0]   idx_sum;
  logic          armed, blink_phase;
  logic [15:0]   blink_cnt, scroll_cnt;
  logic [7:0]    wr_glyph, sel_glyph;
  seg_entry_t    sel;

  seg_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign wrap     = tick && (scan_idx == LAST);
  assign wr_glyph = wr.wr_hex ? hex_to_glyph(wr.wr_data[3:0]) : wr.wr_data;
  assign wr_ok    = wr.wr_en && ({1'b0, wr.wr_addr} < (AW+1)'(N_DIGITS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITS; i++) buffer[i] <= '0;
    end else if (wr.clear) begin
      for (int i = 0; i < N_DIGITS; i++) buffer[i] <= '0;
    end else if (wr_ok) begin
      buffer[wr.wr_addr] <= '{glyph: wr_glyph, blink: wr.wr_blink};
    end
  end

  // armed keeps the anodes dark until the first tick has selected digit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx    <= LAST;
      armed       <= 1'b0;
      frame_done  <= 1'b0;
      blink_phase <= 1'b1;
      blink_cnt   <= '0;
      scroll_off  <= '0;
      scroll_cnt  <= '0;
    end else begin
      frame_done <= tick && (scan_idx == AW'(N_DIGITS - 2));
      if (tick) begin
        scan_idx <= wrap ? '0 : scan_idx + 1'b1;
        armed    <= 1'b1;
      end
      if (wrap) begin
        if (blink_cnt == 16'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
      if (!scroll_en) begin
        scroll_off <= '0;
        scroll_cnt <= '0;
      end else if (wrap) begin
        if (scroll_cnt == 16'(SCROLL_FRAMES - 1)) begin
          scroll_cnt <= '0;
          scroll_off <= (scroll_off == LAST) ? '0 : scroll_off + 1'b1;
        end else begin
          scroll_cnt <= scroll_cnt + 16'd1;
        end
      end
    end
  end

  // Sum is one bit wider than the index so non-power-of-two depths wrap correctly
  always_comb begin
    idx_sum   = {1'b0, scan_idx} + {1'b0, scroll_off};
    sel_idx   = AW'((idx_sum >= (AW+1)'(N_DIGITS)) ? idx_sum - (AW+1)'(N_DIGITS) : idx_sum);
    sel       = buffer[sel_idx];
    sel_glyph = (sel.blink && !blink_phase) ? GLYPH_BLANK : sel.glyph;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_out <= '0;
      an_out  <= '0;
    end else if (!enable || !armed) begin
      seg_out <= '0;
      an_out  <= '0;
    end else begin
      seg_out <= sel_glyph;
      an_out  <= N_DIGITS'(1) << scan_idx;
    end
  end
endmodule
